// File: rtl/pcie_dll_replay_ctrl_pkg.sv
// Shared types for the DLL replay controller: 12-bit sequence numbers and replay FSM states.
package pcie_dll_replay_ctrl_pkg;

   typedef logic [11:0] seq_t;
   localparam int SEQ_W = 12;

   typedef enum logic {RPL_IDLE, RPL_REPLAY} replay_state_t;

   // Modulo-4096 distance from b forward to a.
   function automatic seq_t seq_diff(input seq_t a, input seq_t b);
      return seq_t'(a - b);
   endfunction

endpackage

// File: rtl/pcie_replay_timer.sv
// Replay timer: free-running count with start/restart/freeze/stop controls and an expiry flag.
module pcie_replay_timer #(
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic restart,
   input  logic freeze,
   input  logic stop,
   output logic expire
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic             running;
   logic [CNT_W-1:0] count;

   // Stop wins over restart so an empty buffer never leaves the timer armed.
   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         count   <= '0;
      end else if (stop) begin
         running <= 1'b0;
         count   <= '0;
      end else if (restart || (start && !running)) begin
         running <= 1'b1;
         count   <= '0;
      end else if (running && !freeze && (count != LIMIT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = running && !freeze && (count == LIMIT);

endmodule

// File: rtl/pcie_dll_replay_ctrl.sv
// DLL TX retry-buffer sequencer: sequence assignment, ACK/NAK purge, replay timer and replay arbitration.
module pcie_dll_replay_ctrl
   import pcie_dll_replay_ctrl_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int PTR_W          = 4,
   parameter int REPLAY_TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tlp_valid_i,
   output logic             tlp_ready_o,
   output logic [11:0]      tlp_seq_o,
   output logic             buf_wr_en_o,
   output logic [PTR_W-1:0] buf_wr_ptr_o,
   output logic             buf_rd_en_o,
   output logic [PTR_W-1:0] buf_rd_ptr_o,
   output logic             replay_valid_o,
   input  logic             phy_ready_i,
   input  logic             ack_valid_i,
   input  logic             nak_valid_i,
   input  logic [11:0]      ackd_seq_i,
   output logic             replay_active_o,
   output logic [PTR_W:0]   occupancy_o,
   output logic             retrain_req_o,
   output logic             dll_err_o
);

   replay_state_t    state, state_n;
   seq_t             next_seq, ackd_seq, next_seq_n, ackd_seq_n;
   seq_t             occ, occ_n, d;
   logic [PTR_W-1:0] wr_ptr, rd_base, rd_ptr, end_ptr;
   logic [PTR_W-1:0] wr_ptr_n, rd_base_n, rd_inc, rd_step, rd_off;
   logic [1:0]       replay_num, replay_num_base, replay_num_n;
   logic             retrain_q, err_q;
   logic             full, accept, ack_nak, in_window, purge, win_err, nak_req;
   logic             expire, trigger, fire, last, leave, passed;

   assign occ       = seq_t'(seq_diff(next_seq, ackd_seq) - seq_t'(1));
   assign full      = (occ == seq_t'(DEPTH));
   assign accept    = tlp_valid_i && tlp_ready_o;
   assign ack_nak   = ack_valid_i || nak_valid_i;
   assign d         = seq_diff(ackd_seq_i, ackd_seq);
   assign in_window = (d <= occ);
   assign purge     = ack_nak && in_window && (d != '0);
   assign win_err   = ack_nak && !in_window;
   assign nak_req   = nak_valid_i && in_window;

   assign next_seq_n = accept ? seq_t'(next_seq + seq_t'(1)) : next_seq;
   assign ackd_seq_n = purge ? ackd_seq_i : ackd_seq;
   assign occ_n      = seq_t'(seq_diff(next_seq_n, ackd_seq_n) - seq_t'(1));
   assign wr_ptr_n   = accept ? wr_ptr + PTR_W'(1) : wr_ptr;
   assign rd_base_n  = purge ? rd_base + d[PTR_W-1:0] : rd_base;

   // A replay is only worth scheduling if something is left after this cycle's purge.
   assign trigger = (state == RPL_IDLE) && (nak_req || expire) && (occ_n != '0);
   assign fire    = (state == RPL_REPLAY) && phy_ready_i;
   assign rd_inc  = rd_ptr + PTR_W'(1);
   assign last    = fire && (rd_inc == end_ptr);
   assign leave   = (state == RPL_REPLAY) && (last || (occ_n == '0));
   assign rd_step = fire ? rd_inc : rd_ptr;
   assign rd_off  = rd_step - rd_base;
   assign passed  = purge && (d > seq_t'(rd_off));

   assign replay_num_base = purge ? 2'd0 : replay_num;
   assign replay_num_n    = trigger ? replay_num_base + 2'd1 : replay_num_base;

   always_comb begin
      state_n = state;
      case (state)
         RPL_IDLE:   if (trigger) state_n = RPL_REPLAY;
         RPL_REPLAY: if (leave)   state_n = RPL_IDLE;
         default:    state_n = RPL_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RPL_IDLE;
         next_seq   <= '0;
         ackd_seq   <= seq_t'(12'hFFF);
         wr_ptr     <= '0;
         rd_base    <= '0;
         rd_ptr     <= '0;
         end_ptr    <= '0;
         replay_num <= '0;
         retrain_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_n;
         next_seq   <= next_seq_n;
         ackd_seq   <= ackd_seq_n;
         wr_ptr     <= wr_ptr_n;
         rd_base    <= rd_base_n;
         replay_num <= replay_num_n;
         retrain_q  <= trigger && (replay_num_base == 2'd3);
         err_q      <= win_err;
         // end_ptr includes a TLP accepted in the trigger cycle.
         if (trigger) begin
            rd_ptr  <= rd_base_n;
            end_ptr <= wr_ptr_n;
         end else if (state == RPL_REPLAY) begin
            rd_ptr <= passed ? rd_base_n : rd_step;
         end
      end
   end

   pcie_replay_timer #(.TIMEOUT(REPLAY_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (accept),
      .restart (purge || trigger || leave),
      .freeze  (state == RPL_REPLAY),
      .stop    (occ_n == '0),
      .expire  (expire)
   );

   assign tlp_ready_o     = !rst && (state == RPL_IDLE) && !full && phy_ready_i;
   assign tlp_seq_o       = next_seq;
   assign buf_wr_en_o     = tlp_valid_i && tlp_ready_o;
   assign buf_wr_ptr_o    = wr_ptr;
   assign buf_rd_en_o     = !rst && fire;
   assign replay_valid_o  = !rst && fire;
   assign buf_rd_ptr_o    = rd_ptr;
   assign replay_active_o = !rst && (state == RPL_REPLAY);
   assign occupancy_o     = rst ? '0 : occ[PTR_W:0];
   assign retrain_req_o   = !rst && retrain_q;
   assign dll_err_o       = !rst && err_q;

endmodule

// File: tb/tb_pcie_dll_replay_ctrl.sv
// Directed bench for pcie_dll_replay_ctrl: sequencing, ACK/NAK purge, replays, timeouts and reset.
module tb_pcie_dll_replay_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tlp_valid_i = 1'b0;
   logic        tlp_ready_o;
   logic [11:0] tlp_seq_o;
   logic        buf_wr_en_o;
   logic [3:0]  buf_wr_ptr_o;
   logic        buf_rd_en_o;
   logic [3:0]  buf_rd_ptr_o;
   logic        replay_valid_o;
   logic        phy_ready_i = 1'b1;
   logic        ack_valid_i = 1'b0;
   logic        nak_valid_i = 1'b0;
   logic [11:0] ackd_seq_i = '0;
   logic        replay_active_o;
   logic [4:0]  occupancy_o;
   logic        retrain_req_o;
   logic        dll_err_o;

   int vectors = 0;
   int miscompares = 0;
   int bench_next;
   int n;
   int hits;

   always #5 clk = ~clk;

   pcie_dll_replay_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .tlp_valid_i     (tlp_valid_i),
      .tlp_ready_o     (tlp_ready_o),
      .tlp_seq_o       (tlp_seq_o),
      .buf_wr_en_o     (buf_wr_en_o),
      .buf_wr_ptr_o    (buf_wr_ptr_o),
      .buf_rd_en_o     (buf_rd_en_o),
      .buf_rd_ptr_o    (buf_rd_ptr_o),
      .replay_valid_o  (replay_valid_o),
      .phy_ready_i     (phy_ready_i),
      .ack_valid_i     (ack_valid_i),
      .nak_valid_i     (nak_valid_i),
      .ackd_seq_i      (ackd_seq_i),
      .replay_active_o (replay_active_o),
      .occupancy_o     (occupancy_o),
      .retrain_req_o   (retrain_req_o),
      .dll_err_o       (dll_err_o)
   );

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic ack, input logic nak, input int seq, input logic ready);
      tlp_valid_i = valid;
      ack_valid_i = ack;
      nak_valid_i = nak;
      ackd_seq_i  = 12'(seq);
      phy_ready_i = ready;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Counts negedges until a replay starts; gives up after 1200.
   task automatic wait_replay(output int cycles);
      cycles = 0;
      while (!replay_active_o && cycles < 1200) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   initial begin
      // Reset values while rst is high
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      check_output("rst_tlp_ready", tlp_ready_o, 0);
      check_output("rst_wr_en", buf_wr_en_o, 0);
      check_output("rst_occupancy", occupancy_o, 0);
      check_output("rst_replay_active", replay_active_o, 0);
      rst = 1'b0;

      // Test 1: three TLPs
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
         #1;
         check_output("t1_ready", tlp_ready_o, 1);
         check_output("t1_wr_en", buf_wr_en_o, 1);
         check_output("t1_seq", tlp_seq_o, i);
         check_output("t1_wr_ptr", buf_wr_ptr_o, i);
         @(negedge clk);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 1, 1'b1);
      #1;
      check_output("t1_occupancy", occupancy_o, 3);

      // Test 2: ACK 1, then duplicate ACK 1
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1, 1'b1);
      #1;
      check_output("t2_occupancy", occupancy_o, 1);
      check_output("t2_rd_base", dut.rd_base, 2);
      check_output("t2_timer_restart", dut.u_timer.count, 0);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("t2_dup_occupancy", occupancy_o, 1);
      check_output("t2_dup_no_err", dll_err_o, 0);
      check_output("t2_dup_timer", dut.u_timer.count, 1);

      // Test 3: fill to 16, then out-of-window ACK
      for (int i = 0; i < 15; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
         @(negedge clk);
      end
      apply_stimulus(1'b1, 1'b1, 1'b0, 4000, 1'b1);
      #1;
      check_output("t3_full_ready", tlp_ready_o, 0);
      check_output("t3_full_wr_en", buf_wr_en_o, 0);
      check_output("t3_occupancy", occupancy_o, 16);
      check_output("t3_wr_ptr", buf_wr_ptr_o, 2);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("t3_err_pulse", dll_err_o, 1);
      check_output("t3_occ_kept", occupancy_o, 16);
      @(negedge clk);
      #1;
      check_output("t3_err_cleared", dll_err_o, 0);

      // Test 4: five TLPs, NAK 2, replay ptrs 3 and 4 with a 2-cycle stall
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
         @(negedge clk);
      end
      apply_stimulus(1'b0, 1'b0, 1'b1, 2, 1'b1);
      #1;
      check_output("t4_occ_before", occupancy_o, 5);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("t4_active", replay_active_o, 1);
      check_output("t4_occ_after", occupancy_o, 2);
      check_output("t4_rd_base", dut.rd_base, 3);
      check_output("t4_rd_en0", buf_rd_en_o, 1);
      check_output("t4_valid0", replay_valid_o, 1);
      check_output("t4_ptr0", buf_rd_ptr_o, 3);
      check_output("t4_no_new_tlp", tlp_ready_o, 0);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
      #1;
      check_output("t4_stall_rd_en", buf_rd_en_o, 0);
      check_output("t4_stall_valid", replay_valid_o, 0);
      check_output("t4_stall_ptr", buf_rd_ptr_o, 4);
      @(negedge clk);
      #1;
      check_output("t4_stall2_ptr", buf_rd_ptr_o, 4);
      check_output("t4_stall2_active", replay_active_o, 1);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("t4_ptr1", buf_rd_ptr_o, 4);
      check_output("t4_rd_en1", buf_rd_en_o, 1);
      @(negedge clk);
      #1;
      check_output("t4_back_idle", replay_active_o, 0);
      check_output("t4_idle_rd_en", buf_rd_en_o, 0);
      check_output("t4_idle_ready", tlp_ready_o, 1);
      check_output("t4_replay_num", dut.replay_num, 1);

      // Test 5: one TLP, four timeouts, retrain on the fourth
      do_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         wait_replay(n);
         #1;
         check_output("t5_timeout_cycles", n, 1024);
         check_output("t5_entry_active", replay_active_o, 1);
         check_output("t5_retrain", retrain_req_o, (k == 3) ? 1 : 0);
         check_output("t5_rd_ptr", buf_rd_ptr_o, 0);
         check_output("t5_replay_num", dut.replay_num, (k + 1) % 4);
         @(negedge clk);
         #1;
         check_output("t5_exit", replay_active_o, 0);
         check_output("t5_retrain_pulse", retrain_req_o, 0);
      end

      // Test 6: wrap of the sequence number
      do_reset();
      bench_next = 0;
      while (bench_next < 4094) begin
         apply_stimulus(1'b1, bench_next != 0, 1'b0, bench_next - 1, 1'b1);
         bench_next++;
         @(negedge clk);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 4093, 1'b1);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("t6_drained", occupancy_o, 0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
         #1;
         check_output("t6_seq", tlp_seq_o, (4094 + i) % 4096);
         check_output("t6_wr_ptr", buf_wr_ptr_o, (14 + i) % 16);
         @(negedge clk);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 0, 1'b1);
      #1;
      check_output("t6_occ3", occupancy_o, 3);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("t6_occ0", occupancy_o, 0);
      check_output("t6_no_err", dll_err_o, 0);
      check_output("t6_timer_stopped", dut.u_timer.running, 0);
      hits = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (replay_active_o) hits++;
      end
      check_output("t6_no_replay", hits, 0);

      // Reset in the middle of a replay
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
         @(negedge clk);
      end
      apply_stimulus(1'b0, 1'b0, 1'b1, 1, 1'b1);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
      #1;
      check_output("rr_active", replay_active_o, 1);
      check_output("rr_occ", occupancy_o, 1);
      check_output("rr_ptr", buf_rd_ptr_o, 2);
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
      @(negedge clk);
      #1;
      check_output("rr_tlp_ready", tlp_ready_o, 0);
      check_output("rr_wr_en", buf_wr_en_o, 0);
      check_output("rr_rd_en", buf_rd_en_o, 0);
      check_output("rr_valid", replay_valid_o, 0);
      check_output("rr_active_rst", replay_active_o, 0);
      check_output("rr_occ_rst", occupancy_o, 0);
      check_output("rr_retrain", retrain_req_o, 0);
      check_output("rr_err", dll_err_o, 0);
      rst = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
      #1;
      check_output("rr_after_active", replay_active_o, 0);
      check_output("rr_after_seq", tlp_seq_o, 0);
      check_output("rr_after_ready", tlp_ready_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
